muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers for the 5-stage MIPS pipeline; sits beside the Execute stage.
- Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles while the rest of the pipeline keeps running.
- Drives a stall request when an instruction needs HI/LO, or issues a new op, while a calculation is in flight.
- Handles MTHI/MTLO writes and divide-by-zero.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, sitting beside the EX stage.
// Shift-add multiply and restoring divide, one radix-2 step per clock, sign fixed up at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      count;
  logic               div_q;
  logic               sign_q;
  logic               sign_r;
  logic               b_zero;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               is_signed;
  logic               run_last;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign run_last  = (count == CW'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (run_last) begin
          next_state = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

  // acc holds {product high, multiplier} for multiply and the dividend/quotient in its low half for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_shift = {rem, acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd};
    product   = sign_q ? -acc : acc;
    quot_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sign_r ? -rem : rem;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      div_q       <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      b_zero      <= 1'b0;
      opnd        <= '0;
      a_raw       <= '0;
      acc         <= '0;
      rem         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            div_q       <= op[1];
            opnd        <= op[1] ? mag_b : mag_a;
            acc         <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            rem         <= '0;
            count       <= '0;
            sign_q      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r      <= is_signed & a[WIDTH-1];
            b_zero      <= (b == '0);
            a_raw       <= a;
            div_by_zero <= 1'b0;
          end else begin
            if (wr_hi) begin
              hi <= a;
            end
            if (wr_lo) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (div_q) begin
            if (!rem_diff[WIDTH]) begin
              rem                <= rem_diff[WIDTH-1:0];
              acc[WIDTH-1:0]     <= {acc[WIDTH-2:0], 1'b1};
            end else begin
              rem                <= rem_shift[WIDTH-1:0];
              acc[WIDTH-1:0]     <= {acc[WIDTH-2:0], 1'b0};
            end
          end else if (acc[0]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!div_q) begin
            {hi, lo} <= product;
          end else if (b_zero) begin
            lo          <= '1;
            hi          <= a_raw;
            div_by_zero <= 1'b1;
          end else begin
            lo <= quot_fix;
            hi <= rem_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit and an 8-bit instance run every scenario side by side.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        wr_hi;
  logic        wr_lo;

  logic        busy32, stall32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy8, stall8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] last_hi32, last_lo32, last_hi8, last_lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .busy(busy32), .stall(stall32), .done(done32), .div_by_zero(dbz32),
    .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
    .rd_hilo(rd_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .busy(busy8), .stall(stall8), .done(done8), .div_by_zero(dbz8),
    .hi(hi8), .lo(lo8)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference results computed with plain 64-bit arithmetic at operand width w
  function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t m;
    logic [63:0] mask, ux, uy, p, qv, rv;
    longint sx, sy;
    mask = (64'd1 << w) - 64'd1;
    ux   = {32'd0, x} & mask;
    uy   = {32'd0, y} & mask;
    sx   = ux[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy   = uy[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    m.dbz      = 1'b0;
    m.done_cyc = 0;
    if (!o[1]) begin
      p    = o[0] ? ux * uy : 64'(sx * sy);
      m.hi = 32'((p >> w) & mask);
      m.lo = 32'(p & mask);
    end else if (uy == 64'd0) begin
      m.lo  = 32'(mask);
      m.hi  = 32'(ux);
      m.dbz = 1'b1;
    end else begin
      qv   = o[0] ? ux / uy : 64'(sx / sy);
      rv   = o[0] ? ux % uy : 64'(sx % sy);
      m.lo = 32'(qv & mask);
      m.hi = 32'(rv & mask);
    end
    return m;
  endfunction

  always @(negedge clock) begin : mon32
    exp_t e;
    if (!reset && done32) begin
      if (q32.size() == 0) begin
        checkOutput("spurious_done32", 64'(done32), 64'd0);
      end else begin
        e = q32.pop_front();
        checkOutput("hi32", 64'(hi32), 64'(e.hi));
        checkOutput("lo32", 64'(lo32), 64'(e.lo));
        checkOutput("dbz32", 64'(dbz32), 64'(e.dbz));
        checkOutput("latency32", 64'(cycle), 64'(e.done_cyc));
      end
    end
  end

  always @(negedge clock) begin : mon8
    exp_t e;
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        checkOutput("spurious_done8", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("hi8", 64'(hi8), 64'(e.hi));
        checkOutput("lo8", 64'(lo8), 64'(e.lo));
        checkOutput("dbz8", 64'(dbz8), 64'(e.dbz));
        checkOutput("latency8", 64'(cycle), 64'(e.done_cyc));
      end
    end
  end

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy32 && !busy8) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("idle_timeout", 64'(busy32 | busy8), 64'd0);
  endtask

  // Issues one op to both units at a negedge; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit no_wait = 1'b0);
    exp_t e32, e8;
    if (!no_wait) waitIdle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e32 = model(32, o, x, y);
    e8  = model(8, o, x, y);
    e32.done_cyc = cycle + 34;
    e8.done_cyc  = cycle + 10;
    #1;
    checkOutput("stall_issue32", 64'(stall32), 64'd0);
    checkOutput("stall_issue8", 64'(stall8), 64'd0);
    @(posedge clock);
    q32.push_back(e32);
    q8.push_back(e8);
    last_hi32 = e32.hi;
    last_lo32 = e32.lo;
    last_hi8  = e8.hi;
    last_lo8  = e8.lo;
    #1;
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    @(negedge clock);
    checkOutput("busy_after_start32", 64'(busy32), 64'd1);
    checkOutput("busy_after_start8", 64'(busy8), 64'd1);
    checkOutput("dbz_clear32", 64'(dbz32), 64'd0);
    checkOutput("dbz_clear8", 64'(dbz8), 64'd0);
  endtask

  initial begin
    logic [31:0] old_hi32, old_hi8, old_lo32, old_lo8;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    rd_hilo = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    last_hi32 = '0; last_lo32 = '0; last_hi8 = '0; last_lo8 = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_hi32", 64'(hi32), 64'd0);
    checkOutput("rst_lo32", 64'(lo32), 64'd0);
    checkOutput("rst_busy32", 64'(busy32), 64'd0);
    checkOutput("rst_done32", 64'(done32), 64'd0);
    checkOutput("rst_dbz32", 64'(dbz32), 64'd0);
    checkOutput("rst_hilo8", {hi8, lo8}, 64'd0);
    reset = 1'b0;

    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5);
    waitIdle();
    checkOutput("tp_mult_hi32", 64'(hi32), 64'hFFFFFFFF);
    checkOutput("tp_mult_lo32", 64'(lo32), 64'hFFFFFFF1);
    checkOutput("tp_mult_dbz32", 64'(dbz32), 64'd0);
    checkOutput("tp_mult_hi8", 64'(hi8), 64'hFF);
    checkOutput("tp_mult_lo8", 64'(lo8), 64'hF1);

    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle();
    checkOutput("tp_multu_hi32", 64'(hi32), 64'hFFFFFFFE);
    checkOutput("tp_multu_lo32", 64'(lo32), 64'h1);
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2);
    waitIdle();
    checkOutput("tp_div_lo32", 64'(lo32), 64'hFFFFFFFD);
    checkOutput("tp_div_hi32", 64'(hi32), 64'hFFFFFFFF);
    applyStimulus(2'b11, 32'd7, 32'd3);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF);
    waitIdle();
    checkOutput("tp_ovf_lo32", 64'(lo32), 64'h80000000);
    checkOutput("tp_ovf_hi32", 64'(hi32), 64'h0);
    applyStimulus(2'b10, 32'hFFFFFF80, 32'hFFFFFFFF);
    applyStimulus(2'b11, 32'h1234, 32'd0);
    waitIdle();
    checkOutput("tp_dz_lo32", 64'(lo32), 64'hFFFFFFFF);
    checkOutput("tp_dz_hi32", 64'(hi32), 64'h1234);
    checkOutput("tp_dz_flag32", 64'(dbz32), 64'd1);
    repeat (2) @(negedge clock);
    checkOutput("dz_sticky32", 64'(dbz32), 64'd1);
    applyStimulus(2'b01, 32'd2, 32'd3);

    // MFHI/MFLO waiting on a divide: stall holds exactly while each unit is busy
    applyStimulus(2'b11, 32'hDEADBEEF, 32'h00000013);
    rd_hilo = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clock);
      checkOutput($sformatf("stall_rd32_c%0d", j), 64'(stall32), (j <= 32) ? 64'd1 : 64'd0);
      checkOutput($sformatf("stall_rd8_c%0d", j), 64'(stall8), (j <= 8) ? 64'd1 : 64'd0);
    end
    rd_hilo = 1'b0;

    old_hi32 = last_hi32;
    old_hi8  = last_hi8;
    applyStimulus(2'b01, 32'd300, 32'd400);
    wr_hi = 1'b1;
    a     = 32'h0000AAAA;
    #1;
    checkOutput("stall_wrhi32", 64'(stall32), 64'd1);
    checkOutput("stall_wrhi8", 64'(stall8), 64'd1);
    @(negedge clock);
    wr_hi = 1'b0;
    checkOutput("wrhi_busy32", 64'(hi32), 64'(old_hi32));
    checkOutput("wrhi_busy8", 64'(hi8), 64'(old_hi8[7:0]));
    waitIdle();
    @(negedge clock);
    wr_lo = 1'b1;
    a     = 32'h00000055;
    @(negedge clock);
    wr_lo = 1'b0;
    checkOutput("wrlo_idle32", 64'(lo32), 64'h55);
    checkOutput("wrlo_idle8", 64'(lo8), 64'h55);
    last_lo32 = 32'h55;
    last_lo8  = 32'h55;

    old_lo32 = last_lo32;
    old_lo8  = last_lo8;
    waitIdle();
    wr_lo = 1'b1;
    applyStimulus(2'b01, 32'd9, 32'd7, 1'b1);
    checkOutput("start_beats_wr32", 64'(lo32), 64'(old_lo32));
    checkOutput("start_beats_wr8", 64'(lo8), 64'(old_lo8[7:0]));

    applyStimulus(2'b00, 32'd11, 32'hFFFFFFF0);
    start = 1'b1;
    op    = 2'b01;
    a     = 32'd1;
    b     = 32'd1;
    #1;
    checkOutput("stall_start_busy32", 64'(stall32), 64'd1);
    @(negedge clock);
    start = 1'b0;

    for (int i = 0; i < 16; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = $urandom;
      if (i % 5 == 0) ry = 32'd0;
      if (i % 3 == 1) ry = ry & 32'h0000000F;
      applyStimulus(2'(i % 4), rx, ry);
    end

    // Abort a multiply mid-run; then issue on the very first edge after release
    applyStimulus(2'b00, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(negedge clock);
    #2;
    reset = 1'b1;
    q32.delete();
    q8.delete();
    #1;
    checkOutput("abort_busy32", 64'(busy32), 64'd0);
    checkOutput("abort_hilo32", {hi32, lo32}, 64'd0);
    checkOutput("abort_busy8", 64'(busy8), 64'd0);
    checkOutput("abort_hilo8", {hi8, lo8}, 64'd0);
    repeat (2) @(negedge clock);
    checkOutput("abort_nodone32", 64'(done32), 64'd0);
    reset = 1'b0;
    applyStimulus(2'b01, 32'd2, 32'd3, 1'b1);

    waitIdle();
    repeat (3) @(negedge clock);
    checkOutput("sb_empty32", 64'(q32.size()), 64'd0);
    checkOutput("sb_empty8", 64'(q8.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
